// File: rtl/spike_tx_queue.sv
// Spike transmit queue: a FIFO of {addr, payload} events drained one at a time onto an interconnect write port.
// Optional SPIKE_TX_DROP_EN: never back-pressures the core; pushes into a full FIFO are discarded and counted.
module spike_tx_queue #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [DATA_W-1:0]          push_data,
  output logic [ADDR_W-1:0]          ic_n_addr,
  output logic [DATA_W-1:0]          ic_data,
  output logic                       ic_write_en,
  input  logic                       ic_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
`ifdef SPIKE_TX_DROP_EN
  output logic [15:0]                drop_count,
`endif
  output logic [0:0]                 dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + DATA_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [0:0]    state;
  logic          full;
  logic          push_fire;
  logic          pop;

  // Handshake: the core's event is taken at a rising edge when push_valid && push_ready;
  // the interconnect takes the held event at a rising edge when ic_write_en && ic_ready.
  assign full      = (count_q == CW'(DEPTH));
  assign push_fire = push_valid && !full;
  assign pop       = (count_q != '0) && ((state == IDLE) || ic_ready);

`ifdef SPIKE_TX_DROP_EN
  assign push_ready = 1'b1;
`else
  assign push_ready = !full;
`endif

  assign count       = count_q;
  assign ic_write_en = (state == SEND);
  assign busy        = (count_q != '0) || (state == SEND);
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= {push_addr, push_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      state     <= IDLE;
      ic_n_addr <= '0;
      ic_data   <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PW'(1);

      case ({push_fire, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      // The output register is only ever refilled from the FIFO head.
      if (pop) begin
        rd_ptr               <= rd_ptr + PW'(1);
        {ic_n_addr, ic_data} <= mem[rd_ptr];
        state                <= SEND;
      end else if ((state == SEND) && ic_ready) begin
        state <= IDLE;
      end
    end
  end

`ifdef SPIKE_TX_DROP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (push_valid && full && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spike_tx_queue.sv
// Bench for spike_tx_queue: table-driven vectors, hand sequences and randomized traffic vs a count-based model.
module tb_spike_tx_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        push_valid;
  logic        push_ready;
  logic [1:0]  push_addr;
  logic [31:0] push_data;
  logic [1:0]  ic_n_addr;
  logic [31:0] ic_data;
  logic        ic_write_en;
  logic        ic_ready;
  logic [2:0]  count;
  logic        busy;
  logic [0:0]  dbg_state;
`ifdef SPIKE_TX_DROP_EN
  logic [15:0] drop_count;
  localparam bit DROP_MODE = 1'b1;
`else
  localparam bit DROP_MODE = 1'b0;
`endif

  spike_tx_queue #(.ADDR_W(2), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_data(push_data),
    .ic_n_addr(ic_n_addr), .ic_data(ic_data),
    .ic_write_en(ic_write_en), .ic_ready(ic_ready),
    .count(count), .busy(busy),
`ifdef SPIKE_TX_DROP_EN
    .drop_count(drop_count),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard: every accepted, not yet delivered event, oldest first
  logic [33:0] exp_q[$];
  int          m_fifo;
  bit          m_out;
  int          m_drops;

  typedef struct {
    logic        pv;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        rdy;
    logic        exp_we;
    logic [1:0]  exp_addr;
    logic [31:0] exp_data;
    logic [2:0]  exp_cnt;
    logic        exp_full;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_row(input int i, input logic pv, input logic [1:0] a, input logic [31:0] d,
                         input logic r, input logic we, input logic [1:0] ea, input logic [31:0] ed,
                         input logic [2:0] cnt, input logic fl, input logic bz);
    tbl[i].pv = pv; tbl[i].addr = a; tbl[i].data = d; tbl[i].rdy = r;
    tbl[i].exp_we = we; tbl[i].exp_addr = ea; tbl[i].exp_data = ed;
    tbl[i].exp_cnt = cnt; tbl[i].exp_full = fl; tbl[i].exp_busy = bz;
  endtask

  task automatic do_reset();
    push_valid = 1'b0;
    ic_ready   = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_we", ic_write_en, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_busy", busy, 1'b0);
    exp_q.delete();
    m_fifo  = 0;
    m_out   = 1'b0;
    m_drops = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // driver: apply one cycle of inputs, advance the model, compare after the edge
  task automatic step(input logic pv, input logic [1:0] a, input logic [31:0] d, input logic r);
    logic [33:0] e;
    bit hs, acc, pop;
    push_valid = pv;
    push_addr  = a;
    push_data  = d;
    ic_ready   = r;
    #1;
    if (ic_write_en && r) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL hs_unexpected: got event %0h with empty scoreboard", {ic_n_addr, ic_data});
      end else begin
        total--;
        e = exp_q.pop_front();
        chk("hs_event", {ic_n_addr, ic_data}, e);
      end
    end
    hs  = m_out && r;
    acc = pv && (m_fifo != DEPTH);
    pop = (m_fifo != 0) && (!m_out || r);
    if (pv && !acc && m_drops != 16'hFFFF) m_drops++;
    if (acc) exp_q.push_back({a, d});
    m_fifo = m_fifo + int'(acc) - int'(pop);
    m_out  = pop ? 1'b1 : (hs ? 1'b0 : m_out);
    @(posedge clk);
    #1;
    chk("we", ic_write_en, m_out);
    chk("count", count, m_fifo);
    chk("busy", busy, (m_fifo != 0) || m_out);
    chk("push_ready", push_ready, DROP_MODE ? 1'b1 : (m_fifo != DEPTH));
    if (m_out && exp_q.size() != 0) chk("out_event", {ic_n_addr, ic_data}, exp_q[0]);
`ifdef SPIKE_TX_DROP_EN
    chk("drop_count", drop_count, m_drops);
`endif
  endtask

  initial begin
    reset      = 1'b0;
    push_valid = 1'b0;
    push_addr  = '0;
    push_data  = '0;
    ic_ready   = 1'b0;

    // backpressure / full then drain; 6th push is refused (or dropped)
    set_row(0,  1, 2'd1, 32'd1, 0, 0, 2'd0, 32'd0, 3'd1, 0, 1);
    set_row(1,  1, 2'd2, 32'd2, 0, 1, 2'd1, 32'd1, 3'd1, 0, 1);
    set_row(2,  1, 2'd3, 32'd3, 0, 1, 2'd1, 32'd1, 3'd2, 0, 1);
    set_row(3,  1, 2'd0, 32'd4, 0, 1, 2'd1, 32'd1, 3'd3, 0, 1);
    set_row(4,  1, 2'd1, 32'd5, 0, 1, 2'd1, 32'd1, 3'd4, 1, 1);
    set_row(5,  1, 2'd2, 32'd6, 0, 1, 2'd1, 32'd1, 3'd4, 1, 1);
    set_row(6,  0, 2'd0, 32'd0, 1, 1, 2'd2, 32'd2, 3'd3, 0, 1);
    set_row(7,  0, 2'd0, 32'd0, 1, 1, 2'd3, 32'd3, 3'd2, 0, 1);
    set_row(8,  0, 2'd0, 32'd0, 1, 1, 2'd0, 32'd4, 3'd1, 0, 1);
    set_row(9,  0, 2'd0, 32'd0, 1, 1, 2'd1, 32'd5, 3'd0, 0, 1);
    set_row(10, 0, 2'd0, 32'd0, 1, 0, 2'd0, 32'd0, 3'd0, 0, 0);

    do_reset();

    // single event: exactly one cycle of ic_write_en, one edge after accept
    step(1'b1, 2'b01, 32'hA5A5A5A5, 1'b1);
    chk("single_e0_we", ic_write_en, 1'b0);
    step(1'b0, 2'b00, 32'h0, 1'b1);
    chk("single_we", ic_write_en, 1'b1);
    chk("single_evt", {ic_n_addr, ic_data}, {2'b01, 32'hA5A5A5A5});
    step(1'b0, 2'b00, 32'h0, 1'b1);
    chk("single_done_we", ic_write_en, 1'b0);
    chk("single_done_busy", busy, 1'b0);

    // burst: back-to-back pushes, count stays at most 1
    begin
      logic [1:0] ba[4];
      ba[0] = 2'b00; ba[1] = 2'b01; ba[2] = 2'b10; ba[3] = 2'b00;
      for (int i = 0; i < 6; i++) begin
        if (i < 4) step(1'b1, ba[i], 32'(i + 1), 1'b1);
        else       step(1'b0, 2'b00, 32'h0, 1'b1);
        chk("burst_count_le1", count <= 3'd1, 1'b1);
        if (i >= 1 && i <= 4) chk("burst_data", ic_data, 32'(i));
      end
      chk("burst_idle", ic_write_en, 1'b0);
    end

    // table-driven backpressure/full/drain
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].pv, tbl[i].addr, tbl[i].data, tbl[i].rdy);
      chk($sformatf("tbl%0d_we", i), ic_write_en, tbl[i].exp_we);
      chk($sformatf("tbl%0d_cnt", i), count, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_rdy", i), push_ready, DROP_MODE ? 1'b1 : !tbl[i].exp_full);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      if (tbl[i].exp_we)
        chk($sformatf("tbl%0d_evt", i), {ic_n_addr, ic_data}, {tbl[i].exp_addr, tbl[i].exp_data});
    end
`ifdef SPIKE_TX_DROP_EN
    chk("tbl_drops", drop_count, 16'd1);
`endif

    // simultaneous push and pop with count = 2 in SEND
    do_reset();
    step(1'b1, 2'd0, 32'd10, 1'b0);
    step(1'b1, 2'd1, 32'd11, 1'b0);
    step(1'b1, 2'd2, 32'd12, 1'b0);
    chk("sim_pre_count", count, 3'd2);
    step(1'b1, 2'd3, 32'd13, 1'b1);
    chk("sim_count", count, 3'd2);
    chk("sim_data", ic_data, 32'd11);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 32'd0, 1'b1);
    chk("sim_drained", busy, 1'b0);

    // reset mid-operation with count = 3 and ic_write_en = 1
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 32'h100 + 32'(i), 1'b0);
    chk("midrst_pre_count", count, 3'd3);
    chk("midrst_pre_we", ic_write_en, 1'b1);
    do_reset();
    step(1'b1, 2'd3, 32'hBEEF, 1'b1);
    step(1'b0, 2'd0, 32'd0, 1'b1);
    chk("midrst_new_evt", {ic_n_addr, ic_data}, {2'd3, 32'hBEEF});
    step(1'b0, 2'd0, 32'd0, 1'b1);
    chk("midrst_only_new", busy, 1'b0);

`ifdef SPIKE_TX_DROP_EN
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 2'(i), 32'(i + 1), 1'b0);
    chk("drop_count7", drop_count, 16'd2);
    chk("drop_ready", push_ready, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 32'd0, 1'b1);
    chk("drop_drained", busy, 1'b0);
`endif

    // randomized traffic with stall bursts
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic r;
      if ((i / 50) % 2 == 1) r = ($urandom_range(0, 3) == 0);
      else                   r = ($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, r);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 2'd0, 32'd0, 1'b1);
    chk("final_sb_empty", exp_q.size(), 0);
    chk("final_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
